// File: rtl/vecmul_pkg.sv
// Shared definitions for the vector dot-product sequencer and multiplier wrapper.
package vecmul_pkg;

  // Sequencer states; the encoding is fixed so it stays stable in waveforms and debug.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Width needed to hold the sum of n products of two w-bit unsigned values.
  function automatic int acc_width(input int n, input int w);
    return 2 * w + $clog2(n + 1);
  endfunction

endpackage

// File: rtl/issue_tag_pipe.sv
// DEPTH-stage 1-bit delay line.
// Tracks each multiplier issue until its product returns, and emits the accumulate strobe.
module issue_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic tag_in,
  output logic tag_out
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  generate
    if (DEPTH == 1) begin : g_single
      // A one-deep pipe simply samples the incoming tag.
      always_comb pipe_d = tag_in;
    end else begin : g_multi
      // Shift the tags one stage toward the output every cycle.
      always_comb pipe_d = {pipe_q[DEPTH-2:0], tag_in};
    end
  endgenerate

  // Reset drops every in-flight tag, so products of an abandoned operation are never accumulated.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/vector_mul_sequencer.sv
// Streams two latched N-element vectors through an external pipelined multiplier.
// Accumulates the returning products and reports the dot product with a one-cycle done pulse.
module vector_mul_sequencer
  import vecmul_pkg::*;
#(
  parameter int N       = 3,
  parameter int W       = 3,
  parameter int MUL_LAT = 1,
  parameter int ACC_W   = acc_width(N, W)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N*W-1:0]   vec_a,
  input  logic [N*W-1:0]   vec_b,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  output logic             mul_valid,
  input  logic [2*W-1:0]   mul_out,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result
);

  localparam int IDX_W = $clog2(N + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  seq_state_e       state_q, state_d;
  logic [N*W-1:0]   vec_a_q, vec_a_d;
  logic [N*W-1:0]   vec_b_q, vec_b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             mul_valid_q, mul_valid_d;
  logic [W-1:0]     mul_a_q, mul_a_d;
  logic [W-1:0]     mul_b_q, mul_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             acc_strobe;
  logic             last_product;

  issue_tag_pipe #(
    .DEPTH(MUL_LAT)
  ) u_tag_pipe (
    .clock  (clock),
    .reset  (reset),
    .tag_in (mul_valid_q),
    .tag_out(acc_strobe)
  );

  // Next-state logic.
  // Accumulates a returning product whenever its tag exits the pipe.
  // Advances the issue index, and drives the registered outputs for the coming cycle.
  always_comb begin
    state_d      = state_q;
    vec_a_d      = vec_a_q;
    vec_b_d      = vec_b_q;
    idx_d        = idx_q;
    idx_next     = idx_q + IDX_W'(1);
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    result_d     = result_q;
    mul_valid_d  = 1'b0;
    mul_a_d      = '0;
    mul_b_d      = '0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    last_product = acc_strobe && (cnt_q == LAST_IDX);

    if (acc_strobe) begin
      acc_d = acc_q + ACC_W'(mul_out);
      cnt_d = cnt_q + IDX_W'(1);
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = ISSUE;
          vec_a_d     = vec_a;
          vec_b_d     = vec_b;
          idx_d       = '0;
          cnt_d       = '0;
          acc_d       = '0;
          mul_valid_d = 1'b1;
          mul_a_d     = vec_a[W-1:0];
          mul_b_d     = vec_b[W-1:0];
          busy_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (idx_q == LAST_IDX) begin
          if (last_product) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = acc_d;
          end else begin
            state_d = DRAIN;
            busy_d  = 1'b1;
          end
        end else begin
          idx_d       = idx_next;
          mul_valid_d = 1'b1;
          mul_a_d     = vec_a_q[int'(idx_next)*W +: W];
          mul_b_d     = vec_b_q[int'(idx_next)*W +: W];
          busy_d      = 1'b1;
        end
      end
      DRAIN: begin
        if (last_product) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = acc_d;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any operation in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      vec_a_q     <= '0;
      vec_b_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_a_q     <= vec_a_d;
      vec_b_q     <= vec_b_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_valid = mul_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_vector_mul_sequencer.sv
// Self-checking bench for vector_mul_sequencer.
// Covers a one-cycle multiplier instance and a three-cycle multiplier instance.
module tb_vector_mul_sequencer;

  localparam int N     = 3;
  localparam int W     = 3;
  localparam int NW    = N * W;
  localparam int ACC_W = 2 * W + $clog2(N + 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic sel   = 1'b0;
  logic [NW-1:0] vec_a = '0;
  logic [NW-1:0] vec_b = '0;

  logic start0, start1;
  logic [W-1:0] mul_a0, mul_b0, mul_a1, mul_b1;
  logic mul_valid0, mul_valid1, busy0, busy1, done0, done1;
  logic [2*W-1:0] mul_out0, mul_out1;
  logic [ACC_W-1:0] result0, result1;

  logic [2*W-1:0] mp0 = '0;
  logic [2*W-1:0] mp1 [3];

  logic obs_mv, obs_busy, obs_done;
  logic [W-1:0] obs_a, obs_b;
  logic [ACC_W-1:0] obs_result;

  int compared   = 0;
  int mismatched = 0;
  int op_num     = 0;
  int exp_result [2];

  localparam logic [NW-1:0] BASIC_A = 9'b011_010_011;
  localparam logic [NW-1:0] BASIC_B = 9'b010_011_011;

  always #5 clock = ~clock;

  assign start0 = start && !sel;
  assign start1 = start && sel;

  vector_mul_sequencer #(.N(N), .W(W), .MUL_LAT(1)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .vec_a(vec_a), .vec_b(vec_b),
    .mul_a(mul_a0), .mul_b(mul_b0), .mul_valid(mul_valid0), .mul_out(mul_out0),
    .busy(busy0), .done(done0), .result(result0)
  );

  vector_mul_sequencer #(.N(N), .W(W), .MUL_LAT(3)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .vec_a(vec_a), .vec_b(vec_b),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_valid(mul_valid1), .mul_out(mul_out1),
    .busy(busy1), .done(done1), .result(result1)
  );

  // Multiplier models: registered products with one and three cycles of latency.
  always @(posedge clock) begin
    mp0    <= (2*W)'(mul_a0) * (2*W)'(mul_b0);
    mp1[0] <= (2*W)'(mul_a1) * (2*W)'(mul_b1);
    mp1[1] <= mp1[0];
    mp1[2] <= mp1[1];
  end

  assign mul_out0 = mp0;
  assign mul_out1 = mp1[2];

  assign obs_mv     = sel ? mul_valid1 : mul_valid0;
  assign obs_a      = sel ? mul_a1 : mul_a0;
  assign obs_b      = sel ? mul_b1 : mul_b0;
  assign obs_busy   = sel ? busy1 : busy0;
  assign obs_done   = sel ? done1 : done0;
  assign obs_result = sel ? result1 : result0;

  function automatic int elem(input logic [NW-1:0] v, input int i);
    if (i < 0 || i >= N) return 0;
    return int'(v[i*W +: W]);
  endfunction

  function automatic int dot(input logic [NW-1:0] va, input logic [NW-1:0] vb);
    int sum = 0;
    for (int i = 0; i < N; i++) sum += elem(va, i) * elem(vb, i);
    return sum;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One dot product on the selected instance, checking every output on every cycle through done.
  task automatic applyStimulus(input logic [NW-1:0] va, input logic [NW-1:0] vb,
                               input bit hold, input bit poke);
    int lat = sel ? 3 : 1;
    int total = N + lat + 1;
    op_num++;
    vec_a = va;
    vec_b = vb;
    start = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= total; k++) begin
      @(negedge clock);
      if (k == 1 && !hold) start = 1'b0;
      if (poke && k == 2) begin
        vec_a = NW'($urandom);
        vec_b = NW'($urandom);
        start = 1'b1;
      end
      if (poke && k == 3) start = 1'b0;
      if (k == total) exp_result[sel] = dot(va, vb);
      checkOutput($sformatf("op%0d c%0d mul_valid", op_num, k), 32'(obs_mv), 32'(k <= N));
      checkOutput($sformatf("op%0d c%0d mul_a", op_num, k), 32'(obs_a), 32'(elem(va, k - 1)));
      checkOutput($sformatf("op%0d c%0d mul_b", op_num, k), 32'(obs_b), 32'(elem(vb, k - 1)));
      checkOutput($sformatf("op%0d c%0d busy", op_num, k), 32'(obs_busy), 32'(k <= N + lat));
      checkOutput($sformatf("op%0d c%0d done", op_num, k), 32'(obs_done), 32'(k == total));
      checkOutput($sformatf("op%0d c%0d result", op_num, k), 32'(obs_result), 32'(exp_result[sel]));
    end
  endtask

  // One cycle after an operation with start low: the block must be quiet and holding its result.
  task automatic checkIdle(input string tag);
    @(negedge clock);
    checkOutput({tag, " idle mul_valid"}, 32'(obs_mv), 32'd0);
    checkOutput({tag, " idle busy"}, 32'(obs_busy), 32'd0);
    checkOutput({tag, " idle done"}, 32'(obs_done), 32'd0);
    checkOutput({tag, " idle result"}, 32'(obs_result), 32'(exp_result[sel]));
  endtask

  // Bounds total run time in case the design wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_result[0] = 0;
    exp_result[1] = 0;

    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("reset mul_valid", 32'(mul_valid0), 32'd0);
    checkOutput("reset mul_a", 32'(mul_a0), 32'd0);
    checkOutput("reset mul_b", 32'(mul_b0), 32'd0);
    checkOutput("reset busy", 32'(busy0), 32'd0);
    checkOutput("reset done", 32'(done0), 32'd0);
    checkOutput("reset result", 32'(result0), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    applyStimulus(BASIC_A, BASIC_B, 1'b0, 1'b0);
    checkOutput("basic result 21", 32'(exp_result[0]), 32'd21);
    checkIdle("basic");

    applyStimulus({N{3'd7}}, {N{3'd7}}, 1'b0, 1'b0);
    checkIdle("max");
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkIdle("zero");

    applyStimulus(BASIC_A, BASIC_B, 1'b0, 1'b1);
    checkIdle("start_busy");

    applyStimulus(NW'($urandom), NW'($urandom), 1'b1, 1'b0);
    applyStimulus(NW'($urandom), NW'($urandom), 1'b1, 1'b0);
    applyStimulus(NW'($urandom), NW'($urandom), 1'b0, 1'b0);
    checkIdle("b2b");

    vec_a = BASIC_A;
    vec_b = BASIC_B;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset mul_valid", 32'(mul_valid0), 32'd0);
    checkOutput("midreset mul_a", 32'(mul_a0), 32'd0);
    checkOutput("midreset mul_b", 32'(mul_b0), 32'd0);
    checkOutput("midreset busy", 32'(busy0), 32'd0);
    checkOutput("midreset done", 32'(done0), 32'd0);
    checkOutput("midreset result", 32'(result0), 32'd0);
    exp_result[0] = 0;
    exp_result[1] = 0;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      checkOutput($sformatf("post-reset c%0d done", c), 32'(done0), 32'd0);
      checkOutput($sformatf("post-reset c%0d busy", c), 32'(busy0), 32'd0);
    end
    applyStimulus(BASIC_A, BASIC_B, 1'b0, 1'b0);
    checkIdle("after_reset");

    for (int r = 0; r < 6; r++) begin
      applyStimulus(NW'($urandom), NW'($urandom), 1'b0, 1'b0);
      checkIdle("rand0");
    end

    sel = 1'b1;
    @(negedge clock);
    applyStimulus(BASIC_A, BASIC_B, 1'b0, 1'b0);
    checkIdle("lat3 basic");
    for (int r = 0; r < 4; r++) begin
      applyStimulus(NW'($urandom), NW'($urandom), 1'b0, 1'b0);
      checkIdle("rand1");
    end
    applyStimulus(NW'($urandom), NW'($urandom), 1'b1, 1'b0);
    applyStimulus(NW'($urandom), NW'($urandom), 1'b0, 1'b0);
    checkIdle("lat3 b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vector_mul_sequencer.md
# vector_mul_sequencer

Sequences a dot product of two N-element, W-bit unsigned vectors through the shared registered element multiplier. The block latches both packed vectors on `start` and streams one element pair per cycle into the multiplier. It tags each issue so the returning product is accumulated after a fixed latency, then raises `done` with the full sum. It sits between the vector register file and the multiplier and is the multiplier's only driver.

## Interface
- `N`, 3: elements per vector, N ≥ 1
- `W`, 3: element width in bits, W ≥ 1
- `MUL_LAT`, 1: multiplier latency in cycles from operand sample to product valid, MUL_LAT ≥ 1
- `ACC_W`, 2*W+$clog2(N+1): accumulator/result width (derived; never overridden)

Ports:
- `clock` input 1: single clock, all state on rising edge
- `reset` input 1: asynchronous, active-high; clears all state
- `start` input 1: request a new dot product
- `vec_a` input N*W: element i at bits [i*W +: W]
- `vec_b` input N*W: same packing as `vec_a`
- `mul_a` output W: operand A to the multiplier
- `mul_b` output W: operand B to the multiplier
- `mul_valid` output 1: operands on `mul_a`/`mul_b` are a live issue
- `mul_out` input 2*W: product returned by the multiplier
- `busy` output 1: high in ISSUE and DRAIN
- `done` output 1: one-cycle pulse, `result` final
- `result` output ACC_W: dot product, held until the next accepted start

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- In IDLE or DONE, `start`=1 at an edge does the following:
  - latches `vec_a`/`vec_b`
  - clears the accumulator and issue index
  - moves to ISSUE
- `start` in ISSUE or DRAIN is ignored. There is no queueing.
- In ISSUE, the block drives element `idx` of each latched vector and sets `mul_valid`=1. `idx` counts 0..N-1.
  - After issuing element N-1, the next state is DRAIN.
  - If MUL_LAT products are already all returned, the next state is DONE. This case is unreachable for MUL_LAT ≥ 1.
- Issue tags: a MUL_LAT-deep shift register of `mul_valid`. When the tag exits, `mul_out` is added to the accumulator at that edge.
- DRAIN → DONE at the edge where the N-th product is accumulated.
- DONE lasts exactly one cycle, then returns to IDLE unless `start` is accepted.
- Arithmetic: unsigned, zero-extended to ACC_W. Overflow is impossible by construction (max N*(2^W-1)^2).
- When `mul_valid`=0, `mul_a`/`mul_b` are driven to 0.
- `result` is a register updated only on entry to DONE. It holds the previous value throughout the next operation.
- Reset values: state IDLE, all outputs 0, accumulator 0, index 0, tag pipe cleared.
- Reset mid-operation: abandons the operation immediately. In-flight products are discarded, and no `done` is produced afterwards.

## Timing
- Let `start` be accepted at edge E0.
- `mul_valid`=1 in cycles 1..N after E0, with element i in cycle i+1.
- The product for element i is accumulated at edge E(i+1+MUL_LAT).
- `done`=1 in cycle N+MUL_LAT+1 after E0. Latency start→done is N+MUL_LAT+1 cycles.
- `busy`=1 in cycles 1..N+MUL_LAT. Throughput is one dot product per N+MUL_LAT+1 cycles.
- `start` held high continuously: re-accepted on the DONE cycle. The next `mul_valid` follows immediately, with no idle cycle.

## Structure
- Shared package `vecmul_pkg` contains:
  - state encoding (IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
  - accumulator-width function used by ACC_W, also used by the multiplier wrapper
- One sub-module, `issue_tag_pipe`: a parameterised MUL_LAT-deep 1-bit delay line with async reset. It produces the accumulate strobe.
- The multiplier itself is not instantiated here. The bench and top level connect it externally.

## Test plan
- Basic: N=3, W=3, MUL_LAT=1, `vec_a`=9'b011_010_011 (3,2,3), `vec_b`=9'b010_011_011 (3,3,2), one-cycle `start` → `mul_valid` in cycles 1–3 with pairs (3,3),(2,3),(3,2); `done` in cycle 5; `result`=21.
- Max operands: all elements 7 → `result`=147, no truncation (ACC_W=8). Repeat with all 0 → `result`=0 and `done` still pulses in cycle 5.
- Start while busy: pulse `start` with new vectors in cycle 2 → ignored; `result`=21 from the first vectors, `done` pulses once.
- Back-to-back: `start` held high → `done` in cycles 5, 10, 15. `mul_valid` resumes in cycle 6. `result` holds between pulses.
- Reset mid-operation: assert `reset` asynchronously in cycle 3 → all outputs 0 within the same cycle, no `done`. After release, a fresh start gives the correct 21.
- Latency sweep: MUL_LAT=3 with the basic vectors → `done` in cycle 7, `result`=21, accumulation strobes at E4, E5, E6.
